// File: rtl/eq_pkg.sv
// Shared constants, state encoding and output scaling
// for the equalizer band scheduler.
package eq_pkg;

   localparam int NUM_BANDS  = 10;
   localparam int UNITY_GAIN = 128;
   localparam int SAMPLE_W   = 24;
   localparam int GAIN_W     = 8;
   localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;
   localparam int ACC_W      = 37;
   localparam int BAND_W     = 4;
   localparam int ADDR_W     = 8;
   localparam int FRAC_BITS  = 7;

   localparam logic [ADDR_W-1:0] GAIN_ADDR_BASE = 8'h01;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 37'sd8388607;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -37'sd8388608;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      OUT
   } state_t;

   // Drop the Q1.7 fraction, then clamp to the sample range.
   function automatic logic [SAMPLE_W-1:0] sat_shift(
      input logic signed [ACC_W-1:0] acc
   );
      logic signed [ACC_W-1:0] s;
      s = acc >>> FRAC_BITS;
      if (s > SAT_MAX)
         return SAT_MAX[SAMPLE_W-1:0];
      else if (s < SAT_MIN)
         return SAT_MIN[SAMPLE_W-1:0];
      else
         return s[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Shadow/active band gains with register decode.
// Active set is refreshed from shadow only on load.
module eq_gain_bank #(
   parameter int NUM_BANDS  = eq_pkg::NUM_BANDS,
   parameter int UNITY_GAIN = eq_pkg::UNITY_GAIN
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [3:0] rd_sel,
   output logic [7:0] rd_gain
);
   import eq_pkg::*;

   localparam logic [7:0] ADDR_LAST =
      8'(int'(GAIN_ADDR_BASE) + NUM_BANDS - 1);
   localparam logic [7:0] GAIN_RST = 8'(UNITY_GAIN);

   logic [7:0] shadow [NUM_BANDS];
   logic [7:0] active [NUM_BANDS];
   logic       wr_hit;
   logic [7:0] wr_idx;

   assign wr_hit = wr_en
                && (wr_addr >= GAIN_ADDR_BASE)
                && (wr_addr <= ADDR_LAST);
   assign wr_idx = wr_addr - GAIN_ADDR_BASE;

   // Shadow takes writes; active snapshots the old shadow on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            shadow[i] <= GAIN_RST;
            active[i] <= GAIN_RST;
         end
      end else begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            if (wr_hit && wr_idx == 8'(i))
               shadow[i] <= wr_data;
            if (load)
               active[i] <= shadow[i];
         end
      end
   end

   // Gain lookup for the band currently requested.
   always_comb begin
      rd_gain = '0;
      for (int i = 0; i < NUM_BANDS; i++)
         if (rd_sel == 4'(i))
            rd_gain = active[i];
   end

endmodule

// File: rtl/eq_band_scheduler.sv
// Sequences one sample through all EQ bands, scales each
// band by its gain and emits the saturated weighted sum.
module eq_band_scheduler #(
   parameter int NUM_BANDS  = eq_pkg::NUM_BANDS,
   parameter int UNITY_GAIN = eq_pkg::UNITY_GAIN
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [23:0] audio_in,
   input  logic               audio_valid,
   output logic               audio_ready,
   input  logic               gain_wr_en,
   input  logic [7:0]         gain_wr_addr,
   input  logic [7:0]         gain_wr_data,
   output logic signed [23:0] sample_hold,
   output logic               band_req,
   output logic [3:0]         band_sel,
   input  logic               band_ack,
   input  logic signed [23:0] band_data,
   output logic signed [23:0] audio_out,
   output logic               out_valid
);
   import eq_pkg::*;

   localparam logic [3:0] LAST_IDX = 4'(NUM_BANDS - 1);

   state_t                    state;
   state_t                    state_nx;
   logic [3:0]                band_idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [PROD_W-1:0]  prod;
   logic [7:0]                gain;
   logic                      accept;
   logic                      take;
   logic                      last;

   assign accept   = (state == IDLE) && audio_valid;
   assign take     = (state == RUN) && band_ack;
   assign last     = (band_idx == LAST_IDX);
   assign band_sel = band_idx;
   assign prod     = band_data * $signed({1'b0, gain});

   eq_gain_bank #(
      .NUM_BANDS  (NUM_BANDS),
      .UNITY_GAIN (UNITY_GAIN)
   ) u_gain (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .wr_en   (gain_wr_en),
      .wr_addr (gain_wr_addr),
      .wr_data (gain_wr_data),
      .rd_sel  (band_idx),
      .rd_gain (gain)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nx    = state;
      audio_ready = 1'b0;
      band_req    = 1'b0;
      unique case (state)
         IDLE: begin
            audio_ready = 1'b1;
            if (audio_valid)
               state_nx = RUN;
         end
         RUN: begin
            band_req = 1'b1;
            if (band_ack && last)
               state_nx = OUT;
         end
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture, multiply-accumulate and output scaling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_hold <= '0;
         acc         <= '0;
         band_idx    <= '0;
         audio_out   <= '0;
         out_valid   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            sample_hold <= audio_in;
            acc         <= '0;
            band_idx    <= '0;
         end
         if (take) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            if (!last)
               band_idx <= band_idx + 4'd1;
         end
         if (state == OUT) begin
            audio_out <= sat_shift(acc);
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/eq_band_scheduler.md
EQ_BAND_SCHEDULER -- requirements
Module: eq_band_scheduler

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 10, number of equalizer bands sequenced per sample.
REQ-002 SHALL have parameter UNITY_GAIN, default 128, gain code meaning x1.0 (Q1.7).
REQ-003 SHALL have port clk  input  1  single clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port audio_in  input  24  signed input sample.
REQ-006 SHALL have port audio_valid  input  1  input sample present.
REQ-007 SHALL have port audio_ready  output  1  scheduler can accept a sample.
REQ-008 SHALL have port gain_wr_en  input  1  one-cycle gain register write strobe.
REQ-009 SHALL have port gain_wr_addr  input  8  register address; 8'h01..8'h0A select bands 0..9.
REQ-010 SHALL have port gain_wr_data  input  8  unsigned gain code.
REQ-011 SHALL have port sample_hold  output  24  captured sample presented to the filter bank.
REQ-012 SHALL have port band_req  output  1  request for band band_sel output.
REQ-013 SHALL have port band_sel  output  4  band index being requested.
REQ-014 SHALL have port band_ack  input  1  band_data valid for band_sel.
REQ-015 SHALL have port band_data  input  24  signed filtered sample of band band_sel.
REQ-016 SHALL have port audio_out  output  24  signed equalized sample.
REQ-017 SHALL have port out_valid  output  1  one-cycle pulse, audio_out updated.

Function
REQ-018 SHALL implement states IDLE, RUN, OUT.
REQ-019 SHALL drive audio_ready high only in IDLE.
REQ-020 SHALL, in IDLE with audio_valid high, capture audio_in into sample_hold, clear accumulator, set band index 0, copy shadow gains to active gains, and go to RUN.
REQ-021 SHALL, in RUN, hold band_req high and band_sel equal to the band index.
REQ-022 SHALL, on band_ack high in RUN, add band_data x active_gain[band_sel] (signed 24 x unsigned 8, 33-bit product) into a 37-bit signed accumulator and increment the band index.
REQ-023 SHALL go to OUT on the band_ack of band NUM_BANDS-1; band_ack outside RUN ignored.
REQ-024 SHALL, in OUT, load audio_out with accumulator arithmetically shifted right 7, saturated to [-8388608, 8388607], pulse out_valid for exactly one cycle, return to IDLE.
REQ-025 SHALL give latency of 12 cycles from accept edge to out_valid with band_ack held high (1 accept, 10 RUN, 1 OUT).
REQ-026 SHALL hold audio_out between out_valid pulses.
REQ-027 SHALL write gain_wr_data into shadow gain [addr-1] when gain_wr_en and addr in 8'h01..8'h0A; other addresses ignored.
REQ-028 SHALL allow shadow writes in any state; active gains change only at sample accept, so a sample never mixes old and new gains.
REQ-029 SHALL apply a write coinciding with the accept cycle to the following sample, not the current one.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-RUN, immediately enter IDLE, clear audio_out, sample_hold, accumulator, band_req, band_sel, out_valid to 0, and set all shadow and active gains to UNITY_GAIN.

Structure
REQ-031 SHALL take NUM_BANDS, UNITY_GAIN, sample/accumulator widths, gain address base and the state enum from shared package eq_pkg.
REQ-032 SHALL place shadow/active gain registers and address decode in sub-module eq_gain_bank.

Verification
REQ-033 SHALL test reset defaults: after reset, audio_ready=1, out_valid=0, audio_out=0, all gains 128.
REQ-034 SHALL test unity pass-through: band_data=1000 for all bands, ack always high, unity gains -> audio_out=10000, out_valid exactly 12 cycles after accept.
REQ-035 SHALL test per-band gain: write addr 8'h01=0, others 0 except 8'h0A=255, band_data=1000 -> audio_out=1992.
REQ-036 SHALL test saturation: band_data=8388607, all gains 255 -> audio_out=8388607; band_data=-8388608 -> -8388608.
REQ-037 SHALL test gain timing: write mid-RUN and on accept cycle -> current sample uses old gain, next sample uses new gain; writes to 8'h00/8'h0B have no effect.
REQ-038 SHALL test stalled ack and reset: band_ack low 5 cycles on band 3 -> band_sel holds 3, audio_ready stays 0; rst_n low mid-RUN -> IDLE, no out_valid pulse.
